// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: fetches operands from an 8x8 register
// file, drives an external combinational ALU and writes results back.
module alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [2:0] instr_rd,
    input  logic [2:0] instr_rs1,
    input  logic [2:0] instr_rs2,
    input  logic [7:0] instr_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags,
    output logic       flags_update,
    output logic       done,
    output logic       err,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_N  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP      = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDI      = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ALU_BASE = OP_W'(6);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [IDX_W-1:0]  rd_q;
    logic [IDX_W-1:0]  rs1_q;
    logic [IDX_W-1:0]  rs2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] regs [REG_N];

    // Flags are consumed by the external flags register, not by the sequencer.
    logic unused_flags;
    assign unused_flags = ^alu_flags;

    // ALU class is every opcode from 0110 upward.
    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return op >= OP_ALU_BASE;
    endfunction

    // Illegal class sits between LDI and the first ALU opcode.
    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return (op != OP_NOP) && (op != OP_LDI) && !is_alu(op);
    endfunction

    // r0 is hard-wired to zero on every read path.
    function automatic logic [DATA_W-1:0] rf_read(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(0)) ? DATA_W'(0) : regs[idx];
    endfunction

    // Debug read port.
    assign dbg_data = rf_read(dbg_addr);

    // Sequencer FSM, register file and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            instr_ready  <= 1'b0;
            op_q         <= '0;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            result       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            flags_update <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            flags_update <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q        <= instr_op;
                        rd_q        <= instr_rd;
                        rs1_q       <= instr_rs1;
                        rs2_q       <= instr_rs2;
                        imm_q       <= instr_imm;
                        instr_ready <= 1'b0;
                        state       <= is_alu(instr_op) ? READ : WB;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                READ: begin
                    alu_a      <= rf_read(rs1_q);
                    alu_b      <= rf_read(rs2_q);
                    alu_opcode <= op_q;
                    state      <= EXEC;
                end
                EXEC: begin
                    result <= alu_out;
                    state  <= WB;
                end
                WB: begin
                    done <= 1'b1;
                    if (is_alu(op_q)) begin
                        flags_update <= 1'b1;
                        if (rd_q != IDX_W'(0)) begin
                            regs[rd_q] <= result;
                        end
                    end else if (op_q == OP_LDI) begin
                        if (rd_q != IDX_W'(0)) begin
                            regs[rd_q] <= imm_q;
                        end
                    end else if (is_illegal(op_q)) begin
                        err <= 1'b1;
                    end
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU and register model.
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_rs1;
    logic [2:0] instr_rs2;
    logic [7:0] instr_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_out;
    logic [3:0] alu_flags;
    logic       flags_update;
    logic       done;
    logic       err;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    alu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .flags_update (flags_update),
        .done         (done),
        .err          (err),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural ALU: returns {Z,C,V,S, result}.
    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic       v;
        logic [7:0] r;
        w = '0;
        v = 1'b0;
        case (op)
            4'd6:  begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
            4'd7:  begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
            4'd8:  w = {1'b0, a & b};
            4'd9:  w = {1'b0, a | b};
            4'd10: w = {1'b0, a ^ b};
            4'd11: w = {1'b0, ~a};
            4'd12: w = {a, 1'b0};
            4'd13: w = {a[0], 1'b0, a[7:1]};
            4'd14: w = {1'b0, b};
            4'd15: w = {1'b0, a + 8'd1};
            default: w = '0;
        endcase
        r = w[7:0];
        return {(r == 8'd0), w[8], v, r[7], r};
    endfunction

    logic [11:0] alu_res;
    assign alu_res   = alu_model(alu_opcode, alu_a, alu_b);
    assign alu_out   = alu_res[7:0];
    assign alu_flags = alu_res[11:8];

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        err;
        logic        fu;
        logic [63:0] regs;
        int          acc;
        int          lat;
    } exp_t;

    exp_t       q[$];
    logic [7:0] ref_regs [8];
    bit         b2b_prev = 1'b0;
    int         prev_acc = 0;
    int         prev_lat = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Offer one instruction starting at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm, input bit push);
        int   n;
        exp_t e;
        logic [11:0] res;
        n = 0;
        instr_valid = 1'b1;
        while (!instr_ready) begin
            {instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm} = 21'($urandom);
            @(negedge clk);
            n++;
            if (n > 30) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: instr_ready stayed 0 for %0d cycles", n);
                instr_valid = 1'b0;
                b2b_prev = 1'b0;
                return;
            end
        end
        instr_op  = op;
        instr_rd  = rd;
        instr_rs1 = rs1;
        instr_rs2 = rs2;
        instr_imm = imm;
        e.acc = cyc + 1;
        e.lat = (op >= 4'd6) ? 3 : 1;
        if (b2b_prev) chk("accept_spacing", e.acc, prev_acc + prev_lat + 1);
        e.op  = op;
        e.a   = ref_regs[rs1];
        e.b   = ref_regs[rs2];
        e.err = (op >= 4'd2) && (op <= 4'd5);
        e.fu  = (op >= 4'd6);
        res   = alu_model(op, e.a, e.b);
        if (push) begin
            if (op == 4'd1 && rd != 3'd0) ref_regs[rd] = imm;
            if (op >= 4'd6 && rd != 3'd0) ref_regs[rd] = res[7:0];
            for (int i = 0; i < 8; i++) e.regs[i*8 +: 8] = ref_regs[i];
            q.push_back(e);
        end
        prev_acc = e.acc;
        prev_lat = e.lat;
        b2b_prev = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        {instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm} = 21'($urandom);
        repeat (n) @(negedge clk);
        b2b_prev = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every retirement.
    initial begin
        exp_t e;
        dbg_addr = 3'd0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no retirement (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.acc + e.lat);
                    chk("err", int'(err), int'(e.err));
                    chk("flags_update", int'(flags_update), int'(e.fu));
                    if (e.fu) begin
                        chk("alu_a", int'(alu_a), int'(e.a));
                        chk("alu_b", int'(alu_b), int'(e.b));
                        chk("alu_opcode", int'(alu_opcode), int'(e.op));
                    end
                    for (int i = 0; i < 8; i++) begin
                        dbg_addr = 3'(i);
                        #1;
                        chk($sformatf("reg_r%0d", i), int'(dbg_data), int'(e.regs[i*8 +: 8]));
                    end
                end
            end else if (flags_update || err) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_strobe: got flags_update=%0d err=%0d with done=0", flags_update, err);
            end
        end
    end

    // Stimulus.
    initial begin
        int w;
        logic [3:0] op;
        reset       = 1'b0;
        instr_valid = 1'b0;
        {instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm} = '0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'd0;

        repeat (2) @(negedge clk);
        chk("rst_ready", int'(instr_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_opcode", int'(alu_opcode), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(instr_ready), 1);

        // Directed: LDI/ALU add, r0 destination with rs1=rs2, illegal, NOP.
        issue(4'd1, 3'd1, 3'd0, 3'd0, 8'd5, 1'b1);
        issue(4'd1, 3'd2, 3'd0, 3'd0, 8'd3, 1'b1);
        issue(4'd6, 3'd3, 3'd1, 3'd2, 8'd0, 1'b1);
        issue(4'd7, 3'd0, 3'd1, 3'd1, 8'd0, 1'b1);
        issue(4'd3, 3'd5, 3'd1, 3'd2, 8'hAA, 1'b1);
        issue(4'd0, 3'd6, 3'd1, 3'd2, 8'h55, 1'b1);
        // Three chained ALU ops with valid held high.
        issue(4'd6, 3'd4, 3'd3, 3'd1, 8'd0, 1'b1);
        issue(4'd12, 3'd5, 3'd4, 3'd4, 8'd0, 1'b1);
        issue(4'd7, 3'd6, 3'd5, 3'd2, 8'd0, 1'b1);
        idle(6);

        // Reset during EXEC of op 1000 rd=4.
        issue(4'd8, 3'd4, 3'd1, 3'd3, 8'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_alu_a", int'(alu_a), 0);
        chk("midrst_alu_b", int'(alu_b), 0);
        chk("midrst_alu_opcode", int'(alu_opcode), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_ready", int'(instr_ready), 0);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'd0;
        b2b_prev = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", int'(instr_ready), 1);
        issue(4'd0, 3'd4, 3'd0, 3'd0, 8'd0, 1'b1);

        // Randomised traffic.
        for (int k = 0; k < 150; k++) begin
            w = $urandom_range(0, 9);
            if (w <= 3)      op = 4'd1;
            else if (w == 4) op = 4'd0;
            else if (w == 5) op = 4'($urandom_range(2, 5));
            else             op = 4'($urandom_range(6, 15));
            issue(op, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drained", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters: none; data width fixed at 8, register file fixed at 8 x 8-bit (r0..r7), ALU opcode width fixed at 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately, independent of clk.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  sequencer can accept an instruction; a transfer occurs on a rising edge with instr_valid=1 and instr_ready=1.
REQ-006 instr_op  input  4  operation code.
REQ-007 instr_rd, instr_rs1, instr_rs2  input  3 each  destination and source register indices.
REQ-008 instr_imm  input  8  immediate for LDI.
REQ-009 alu_a, alu_b  output  8 each  ALU operands.
REQ-010 alu_opcode  output  4  ALU operation select.
REQ-011 alu_out  input  8  ALU result, combinational from alu_a/alu_b/alu_opcode.
REQ-012 alu_flags  input  4  {Z,C,V,S} from ALU.
REQ-013 flags_update  output  1  one-cycle strobe to the flags register.
REQ-014 done  output  1  one-cycle strobe: instruction retired.
REQ-015 err  output  1  one-cycle strobe, coincident with done: illegal opcode retired.
REQ-016 dbg_addr  input  3 / dbg_data  output  8  combinational register-file read port for verification.

Function
REQ-017 Opcode classes: 0000 NOP; 0001 LDI (rd <- imm); 0010..0101 illegal; 0110..1111 ALU ops, forwarded unchanged on alu_opcode.
REQ-018 FSM states: IDLE, READ, EXEC, WB; instr_ready=1 only in IDLE.
REQ-019 IDLE: on accept, latch op/rd/rs1/rs2/imm; ALU class -> READ; NOP, LDI and illegal -> WB.
REQ-020 READ: load alu_a <- r[rs1], alu_b <- r[rs2], alu_opcode <- op; -> EXEC.
REQ-021 EXEC: capture alu_out into a result register at the end of the cycle; -> WB.
REQ-022 WB: ALU class writes result to r[rd] and asserts flags_update; LDI writes imm to r[rd] without flags_update; NOP writes nothing; illegal writes nothing and asserts err; done=1 in every case; -> IDLE.
REQ-023 alu_a, alu_b and alu_opcode hold their values from READ through WB, so alu_flags are stable when flags_update is sampled.
REQ-024 Latency, accept at edge T: ALU op done at T+3, next accept at T+4 at the earliest; NOP, LDI and illegal done at T+1, next accept at T+2.
REQ-025 r0 reads as 0 always; writes to r0 are discarded, including ALU results, while flags_update still fires for ALU ops.
REQ-026 rs1=rs2 is legal; both operands equal that register.
REQ-027 Back-to-back: an instruction reading a register written by the previous instruction sees the new value (no hazard, strictly sequential).
REQ-028 instr_valid while instr_ready=0 is ignored; payload changes outside IDLE have no effect.
REQ-029 Arithmetic and width: all register values are 8-bit; the sequencer performs no arithmetic itself, and results wrap as delivered by the ALU.

Reset
REQ-030 While reset=0: state=IDLE, r0..r7=0, alu_a=alu_b=0, alu_opcode=0, result register=0, flags_update=done=err=0, instr_ready=0.
REQ-031 instr_ready rises in the first cycle after reset deasserts; reset asserted mid-instruction aborts it with no register write and no strobes.

Verification
REQ-032 LDI r1,5; LDI r2,3; op 0110 rd=3 rs1=1 rs2=2 -> alu_a=5, alu_b=3, alu_opcode=0110 from READ; r3=alu_out in WB; flags_update and done high one cycle at T+3.
REQ-033 op 0111 rd=0 rs1=1 rs2=1 -> alu_a=alu_b=r1, flags_update=1, r0 stays 0, dbg_addr=0 gives 0.
REQ-034 op 0011 -> done=err=1 at T+1, no write to any register, flags_update=0, instr_ready=1 at T+2.
REQ-035 instr_valid held high with 3 consecutive ALU ops -> accepts exactly 4 cycles apart; the second op reads the first op's rd value.
REQ-036 reset=0 pulse during EXEC of op 1000 rd=4 -> r4=0, no done/flags_update, outputs at reset values, IDLE afterward.
REQ-037 NOP -> done=1 at T+1, err=0, flags_update=0, all registers unchanged.
